// File: rtl/as2650_timers_pkg.sv
// Shared definitions for the AS2650 timer peripheral: register offsets,
// CTRL field layout and the prescaler mask helper.
package as2650_timers_pkg;

   localparam int         CNT_W      = 16;
   localparam logic [3:0] DEV_TIMERS = 4'd1;

   typedef enum logic [2:0] {
      REG_CTRL      = 3'd0,
      REG_STATUS    = 3'd1,
      REG_RELOAD_LO = 3'd2,
      REG_RELOAD_HI = 3'd3,
      REG_COUNT_LO  = 3'd4,
      REG_COUNT_HI  = 3'd5,
      REG_RSVD6     = 3'd6,
      REG_RSVD7     = 3'd7
   } reg_e;

   // CTRL[5:0]; the first field is the most significant bit.
   typedef struct packed {
      logic [2:0] ps;
      logic       irq_en;
      logic       autoreload;
      logic       en;
   } ctrl_t;

   // Low PS bits of the prescaler that must all be ones for a tick.
   function automatic logic [7:0] ps_mask(input logic [2:0] ps);
      return 8'((9'd1 << ps) - 9'd1);
   endfunction

endpackage

// File: rtl/as2650_timers_channel.sv
// One 16-bit down-counting timer: prescaler, count, reload, staging byte,
// read shadow, overflow flag and registered interrupt.
module as2650_timers_channel
   import as2650_timers_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_i,
   input  logic       rd_i,
   input  reg_e       reg_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o,
   output logic       irq_o
);

   ctrl_t            ctrl_q, ctrl_d;
   logic             ovf_q, ovf_d, irq_q;
   logic [CNT_W-1:0] count_q, count_d, reload_q, reload_d;
   logic [7:0]       staging_q, staging_d, shadow_q, shadow_d, psc_q, psc_d;
   logic             ctrl_wr, count_wr, tick, ovf_evt;

   assign ctrl_wr  = wr_i && (reg_i == REG_CTRL);
   // A CPU write to the counter takes precedence over a tick in the same clock.
   assign count_wr = wr_i && ((reg_i == REG_COUNT_LO) || (reg_i == REG_COUNT_HI) ||
                              ((reg_i == REG_RELOAD_HI) && !ctrl_q.en));
   assign tick     = ctrl_q.en && ((psc_q & ps_mask(ctrl_q.ps)) == ps_mask(ctrl_q.ps));
   assign ovf_evt  = tick && !count_wr && (count_q == '0);

   always_comb begin
      ctrl_d    = ctrl_q;
      ovf_d     = ovf_q;
      count_d   = count_q;
      reload_d  = reload_q;
      staging_d = staging_q;
      shadow_d  = shadow_q;
      psc_d     = psc_q;

      if (ctrl_wr)        psc_d = '0;
      else if (ctrl_q.en) psc_d = psc_q + 8'd1;

      if (tick && !count_wr) begin
         if (count_q != '0)          count_d = count_q - 16'd1;
         else if (ctrl_q.autoreload) count_d = reload_q;
         else                        ctrl_d.en = 1'b0;
      end

      if (wr_i) begin
         case (reg_i)
            REG_CTRL:      ctrl_d = ctrl_t'(wdata_i[5:0]);
            REG_STATUS:    if (wdata_i[0]) ovf_d = 1'b0;
            REG_RELOAD_LO: staging_d = wdata_i;
            REG_RELOAD_HI: begin
               reload_d = {wdata_i, staging_q};
               if (!ctrl_q.en) count_d = {wdata_i, staging_q};
            end
            REG_COUNT_LO:  count_d[7:0]  = wdata_i;
            REG_COUNT_HI:  count_d[15:8] = wdata_i;
            default: ;
         endcase
      end

      if (rd_i && (reg_i == REG_COUNT_LO)) shadow_d = count_q[15:8];
      // Applied last so a same-clock STATUS clear loses to a new overflow.
      if (ovf_evt) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         count_q   <= '0;
         reload_q  <= '0;
         staging_q <= '0;
         shadow_q  <= '0;
         psc_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         ovf_q     <= ovf_d;
         irq_q     <= ovf_q & ctrl_q.irq_en;
         count_q   <= count_d;
         reload_q  <= reload_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         psc_q     <= psc_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (reg_i)
         REG_CTRL:      rdata_o = {2'b00, ctrl_q};
         REG_STATUS:    rdata_o = {7'd0, ovf_q};
         REG_RELOAD_LO: rdata_o = reload_q[7:0];
         REG_RELOAD_HI: rdata_o = reload_q[15:8];
         REG_COUNT_LO:  rdata_o = count_q[7:0];
         REG_COUNT_HI:  rdata_o = shadow_q;
         default: ;
      endcase
   end

   assign irq_o = irq_q;

endmodule

// File: rtl/as2650_timers.sv
// AS2650 IO-bus timer device: bus_cyc rising-edge access strobe, channel
// decode on bus_addr[3] (bits [5:4] mirror) and the read-data mux.
module as2650_timers
   import as2650_timers_pkg::*;
#(
   parameter int NUM_TIMERS = 2
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       bus_cyc,
   input  logic       bus_we,
   input  logic [5:0] bus_addr,
   input  logic [7:0] bus_data_in,
   output logic [7:0] bus_data_out,
   output logic [1:0] irq
);

   logic       cyc_q;
   logic       strobe;
   logic       unused_addr;
   logic [7:0] ch_rdata [2];

   // Side effects fire only on the first clock of a bus_cyc assertion.
   assign strobe      = bus_cyc & ~cyc_q;
   assign unused_addr = ^bus_addr[5:4];

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) cyc_q <= 1'b0;
      else          cyc_q <= bus_cyc;
   end

   for (genvar n = 0; n < 2; n++) begin : g_ch
      if (n < NUM_TIMERS) begin : g_on
         logic sel;
         assign sel = (bus_addr[3] == 1'(n));
         as2650_timers_channel u_ch (
            .clk_i   (wb_clk_i),
            .rst_i   (wb_rst_i),
            .wr_i    (strobe & bus_we & sel),
            .rd_i    (strobe & ~bus_we & sel),
            .reg_i   (reg_e'(bus_addr[2:0])),
            .wdata_i (bus_data_in),
            .rdata_o (ch_rdata[n]),
            .irq_o   (irq[n])
         );
      end else begin : g_off
         assign ch_rdata[n] = '0;
         assign irq[n]      = 1'b0;
      end
   end

   assign bus_data_out = bus_cyc ? ch_rdata[bus_addr[3]] : 8'h00;

endmodule

// File: tb/tb_as2650_timers.sv
// Bench for as2650_timers: directed vector table, hand-written corner
// sequences, and random bus traffic checked every cycle against a model.
module tb_as2650_timers;

   logic       clk = 1'b0;
   logic       rst;
   logic       bus_cyc = 1'b0;
   logic       bus_we = 1'b0;
   logic [5:0] bus_addr = '0;
   logic [7:0] bus_data_in = '0;
   logic [7:0] bus_data_out;
   logic [1:0] irq;

   int n_total = 0;
   int n_pass  = 0;
   bit mon_on  = 1'b0;

   always #5 clk = ~clk;

   as2650_timers #(.NUM_TIMERS(2)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .bus_cyc      (bus_cyc),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_data_in  (bus_data_in),
      .bus_data_out (bus_data_out),
      .irq          (irq)
   );

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %02h expected %02h at %0t", name, idx, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   bit          m_prev;
   bit          m_en[2], m_auto[2], m_ien[2], m_ovf[2], m_irq[2];
   int unsigned m_ps[2], m_psc[2], m_cnt[2], m_rel[2], m_stg[2], m_shd[2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_prev <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            m_en[c] <= 0; m_auto[c] <= 0; m_ien[c] <= 0; m_ovf[c] <= 0; m_irq[c] <= 0;
            m_ps[c] <= 0; m_psc[c] <= 0; m_cnt[c] <= 0; m_rel[c] <= 0; m_stg[c] <= 0; m_shd[c] <= 0;
         end
      end else begin
         m_prev <= bus_cyc;
         for (int c = 0; c < 2; c++) begin
            bit acc, wr, rd, tick, cw, nen, novf;
            int unsigned r, period, ncnt, din;
            acc    = bus_cyc && !m_prev && (bus_addr[3] == c[0]);
            wr     = acc && bus_we;
            rd     = acc && !bus_we;
            r      = bus_addr[2:0];
            din    = bus_data_in;
            period = 1 << m_ps[c];
            tick   = m_en[c] && ((m_psc[c] % period) == period - 1);
            cw     = wr && (r == 4 || r == 5 || (r == 3 && !m_en[c]));
            ncnt   = m_cnt[c];
            nen    = m_en[c];
            novf   = m_ovf[c];
            m_irq[c] <= m_ovf[c] && m_ien[c];
            if (wr && r == 0)  m_psc[c] <= 0;
            else if (m_en[c])  m_psc[c] <= (m_psc[c] + 1) % 256;
            if (wr && r == 1 && din[0]) novf = 0;
            if (tick && !cw) begin
               if (m_cnt[c] > 0) ncnt = m_cnt[c] - 1;
               else begin
                  novf = 1;
                  if (m_auto[c]) ncnt = m_rel[c];
                  else           nen = 0;
               end
            end
            if (wr) begin
               case (r)
                  0: begin
                     nen = din[0]; m_auto[c] <= din[1]; m_ien[c] <= din[2]; m_ps[c] <= (din >> 3) % 8;
                  end
                  2: m_stg[c] <= din;
                  3: begin
                     m_rel[c] <= din * 256 + m_stg[c];
                     if (!m_en[c]) ncnt = din * 256 + m_stg[c];
                  end
                  4: ncnt = (m_cnt[c] / 256) * 256 + din;
                  5: ncnt = din * 256 + (m_cnt[c] % 256);
                  default: ;
               endcase
            end
            if (rd && r == 4) m_shd[c] <= m_cnt[c] / 256;
            m_cnt[c] <= ncnt;
            m_en[c]  <= nen;
            m_ovf[c] <= novf;
         end
      end
   end

   function automatic logic [7:0] exp_rd();
      int c;
      c = bus_addr[3];
      if (!bus_cyc) return 8'h00;
      case (bus_addr[2:0])
         3'd0: return {2'b00, 3'(m_ps[c]), m_ien[c], m_auto[c], m_en[c]};
         3'd1: return {7'd0, m_ovf[c]};
         3'd2: return 8'(m_rel[c]);
         3'd3: return 8'(m_rel[c] >> 8);
         3'd4: return 8'(m_cnt[c]);
         3'd5: return 8'(m_shd[c]);
         default: return 8'h00;
      endcase
   endfunction

   int mon_idx = 0;
   always @(negedge clk) begin
      if (mon_on) begin
         check("mon_irq", mon_idx, {6'd0, irq}, {6'd0, m_irq[1], m_irq[0]});
         check("mon_rdata", mon_idx, bus_data_out, exp_rd());
         mon_idx++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; bus_cyc = 1'b0; bus_we = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // bus_cyc stays high for 'hold' clock edges; outputs sampled on the first negedge.
   task automatic access(input logic [5:0] a, input logic w, input logic [7:0] d, input int hold,
                         output logic [7:0] rd, output logic [1:0] iq);
      @(posedge clk); #1;
      bus_cyc = 1'b1; bus_addr = a; bus_we = w; bus_data_in = d;
      @(negedge clk);
      rd = bus_data_out;
      iq = irq;
      repeat (hold - 1) @(posedge clk);
      @(posedge clk); #1;
      bus_cyc = 1'b0; bus_we = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int         op;       // 0 = bus access, 1 = reset
      logic [5:0] addr;
      logic       we;
      logic [7:0] data;
      logic [7:0] exp_rd;
      logic [1:0] exp_irq;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(int op, logic [5:0] a, logic w, logic [7:0] d, logic [7:0] e, logic [1:0] i);
      vec_t x;
      x.op = op; x.addr = a; x.we = w; x.data = d; x.exp_rd = e; x.exp_irq = i;
      return x;
   endfunction

   logic [7:0] rd;
   logic [1:0] iq;
   logic [5:0] r_addr;
   logic       r_we;
   logic [7:0] r_data;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1'b1;

      // One-shot, RELOAD=3, CTRL=0x05
      vt.push_back(v(1, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 6'h02, 1, 8'h03, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h03, 1, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h04, 0, 8'h00, 8'h03, 2'b00));
      vt.push_back(v(0, 6'h02, 0, 8'h00, 8'h03, 2'b00));
      vt.push_back(v(0, 6'h00, 1, 8'h05, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h01, 2'b01));
      vt.push_back(v(0, 6'h00, 0, 8'h00, 8'h04, 2'b01));
      vt.push_back(v(0, 6'h04, 0, 8'h00, 8'h00, 2'b01));
      vt.push_back(v(0, 6'h05, 0, 8'h00, 8'h00, 2'b01));
      vt.push_back(v(0, 6'h01, 1, 8'h01, 8'h01, 2'b01));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h00, 2'b00));
      // Auto-reload, reload=1, PS=1: overflow every 4 clocks; clear racing an overflow
      vt.push_back(v(1, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 6'h02, 1, 8'h01, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h03, 1, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h00, 1, 8'h0B, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h01, 2'b00));
      vt.push_back(v(0, 6'h01, 1, 8'h01, 8'h01, 2'b00));
      vt.push_back(v(0, 6'h01, 1, 8'h01, 8'h01, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h01, 0, 8'h00, 8'h01, 2'b00));
      // Channel isolation and address mirrors
      vt.push_back(v(1, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 6'h3C, 1, 8'h10, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h38, 1, 8'h01, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h0C, 0, 8'h00, 8'h0F, 2'b00));
      vt.push_back(v(0, 6'h04, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h00, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h08, 0, 8'h00, 8'h01, 2'b00));
      vt.push_back(v(0, 6'h06, 1, 8'hFF, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h07, 0, 8'h00, 8'h00, 2'b00));
      vt.push_back(v(0, 6'h2C, 0, 8'h00, 8'h03, 2'b00));
      vt.push_back(v(0, 6'h08, 1, 8'h00, 8'h01, 2'b00));
      vt.push_back(v(0, 6'h08, 0, 8'h00, 8'h00, 2'b00));

      foreach (vt[i]) begin
         if (vt[i].op == 1) do_reset();
         else begin
            access(vt[i].addr, vt[i].we, vt[i].data, 1, rd, iq);
            check("vec_rdata", i, rd, vt[i].exp_rd);
            check("vec_irq", i, {6'd0, iq}, {6'd0, vt[i].exp_irq});
         end
      end

      // Reset mid-count: both channels active, irq[1] pending
      do_reset();
      access(6'h05, 1, 8'h01, 1, rd, iq);
      access(6'h00, 1, 8'h05, 1, rd, iq);
      access(6'h08, 1, 8'h05, 1, rd, iq);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_reset_irq", 0, {6'd0, irq}, 8'h02);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("reset_irq", 0, {6'd0, irq}, 8'h00);
      @(posedge clk); #1 rst = 1'b0;
      for (int a = 0; a < 16; a++) begin
         access(6'(a), 0, 8'h00, 1, rd, iq);
         check("reset_reg", a, rd, 8'h00);
      end
      repeat (10) @(posedge clk);
      access(6'h04, 0, 8'h00, 1, rd, iq);
      check("reset_stopped", 0, rd, 8'h00);

      // Shadow: COUNT_HI returns the byte captured at the COUNT_LO read
      do_reset();
      access(6'h05, 1, 8'h12, 1, rd, iq);
      access(6'h04, 1, 8'h03, 1, rd, iq);
      access(6'h00, 1, 8'h01, 1, rd, iq);
      access(6'h04, 0, 8'h00, 1, rd, iq);
      check("shadow_lo", 0, rd, 8'h02);
      @(posedge clk);
      access(6'h05, 0, 8'h00, 1, rd, iq);
      check("shadow_hi", 0, rd, 8'h12);

      // Held bus_cyc on a STATUS clear: one clear only (reload=3, auto, PS=0)
      do_reset();
      access(6'h02, 1, 8'h03, 1, rd, iq);
      access(6'h03, 1, 8'h00, 1, rd, iq);
      access(6'h00, 1, 8'h03, 1, rd, iq);
      access(6'h01, 0, 8'h00, 1, rd, iq);
      access(6'h01, 0, 8'h00, 1, rd, iq);
      check("held_pre", 0, rd, 8'h00);
      access(6'h01, 1, 8'h01, 5, rd, iq);
      check("held_clr_first", 0, rd, 8'h01);
      access(6'h01, 0, 8'h00, 1, rd, iq);
      check("held_clr_once", 0, rd, 8'h01);

      // Held bus_cyc on a COUNT_LO read: shadow latched once
      do_reset();
      access(6'h05, 1, 8'h12, 1, rd, iq);
      access(6'h04, 1, 8'h01, 1, rd, iq);
      access(6'h00, 1, 8'h01, 1, rd, iq);
      access(6'h04, 0, 8'h00, 4, rd, iq);
      check("held_rd_lo", 0, rd, 8'h00);
      access(6'h05, 0, 8'h00, 1, rd, iq);
      check("held_rd_shadow", 0, rd, 8'h12);

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 1200; k++) begin
         if ($urandom_range(0, 249) == 0) do_reset();
         r_addr = 6'($urandom_range(0, 63));
         r_we   = 1'($urandom_range(0, 1));
         r_data = 8'($urandom_range(0, 255));
         if (r_addr[2:0] == 3'd0) r_data[5:3] = 3'($urandom_range(0, 2));
         access(r_addr, r_we, r_data, $urandom_range(1, 3), rd, iq);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      @(posedge clk);
      mon_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
